key_repeat_sequencer: RTL and testbench
=======================================

Name: key_repeat_sequencer

Overview:
- Auto-repeat controller for held game-control keys; turns one level input (key held) into discrete Step pulses: one on press, one after an initial delay, then one per repeat period.
- Sits directly around the team's start/done cycle timers: drives their Start and consumes their Done.
- Has no internal delay counter. Timing comes entirely from an external timer pair selected by Timer_Long.
- Step feeds the game-logic movement FSM.

Parameters:
- CNT_W, 8, width of Step_Count.
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = single step per press, no timer activity.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Key_Held  input  1  key level, already synchronous to Clk
- Timer_Done  input  1  high when the selected external timer has reached zero; idle timer reads 1
- Timer_Start  output  1  one-cycle pulse that loads the selected external timer
- Timer_Long  output  1  timer select: 1 = initial-delay timer, 0 = repeat timer; stable while waiting
- Step  output  1  one-cycle movement pulse
- Repeating  output  1  high while in repeat phase
- Step_Count  output  CNT_W  steps issued since the current press began

Behaviour:
- Clocking: single clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, Timer_Start=0, Timer_Long=1, Step=0, Repeating=0, Step_Count=0, key_prev=1.
  - key_prev resets to 1, so a key held through reset must be released and re-pressed before it acts.
- Press detect: press = Key_Held & ~key_prev. key_prev is registered every cycle.
- Done guard: Timer_Done is ignored in any cycle where registered Timer_Start=1, because the timer has not yet loaded.
- States: IDLE, WAIT_FIRST, WAIT_REPEAT, HOLD.
- IDLE:
  - On press: next cycle Step=1, Step_Count=1.
  - If REPEAT_EN=1: Timer_Start=1, Timer_Long=1, go to WAIT_FIRST.
  - If REPEAT_EN=0: go to HOLD, Timer_Start stays 0.
- WAIT_FIRST:
  - If Key_Held=0: go to IDLE, no Step.
  - Else if guard passes and Timer_Done=1: Step=1, Step_Count+1, Timer_Start=1, Timer_Long=0, Repeating=1, go to WAIT_REPEAT.
- WAIT_REPEAT:
  - If Key_Held=0: go to IDLE, Repeating=0.
  - Else if guard passes and Timer_Done=1: Step=1, Step_Count+1, Timer_Start=1, stay in WAIT_REPEAT.
- HOLD: on Key_Held=0, go to IDLE. No steps while in HOLD.
- Latency:
  - Press sampled at edge k gives Step high during cycle k+1.
  - Step pulses are separated by the timer period plus 2 cycles (1 for the Start pulse, 1 for the Done-to-Step register).
- Simultaneous release and Timer_Done: release wins; no Step, go to IDLE.
- Release and press in the same cycle cannot occur (single level input). Re-press the cycle after release is a valid new press.
- Step_Count:
  - Cleared to 0 on entry to IDLE, so it is 0 while idle.
  - Set to 1 on press.
  - Saturates at 2^CNT_W-1: Step still pulses, count holds.
- Zero-length timer (Done stays 1): steps every 2 cycles; legal.
- Reset mid-operation: all registers return to reset values next edge. A Timer_Start pulse in flight is dropped (forced 0).
- Step, Timer_Start: never high for two consecutive cycles.

Test Plan:
- Bench timer model: initial period 5, repeat period 2, Done semantics as above. Key pressed for 1 cycle then released -> exactly one Step at press+1; Step_Count back to 0 in IDLE; no second Step.
- Key held 30 cycles -> Steps at t=1, 8, 12, 16, 20, 24, 28 (relative to press edge); Repeating rises with the t=8 step; Timer_Long=1 only until t=8.
- Release on the exact cycle the first-delay Done is seen -> no second Step; state IDLE; Repeating stays 0.
- Key held through Reset deassertion -> no Step until release then re-press; re-press gives Step next cycle, Step_Count=1.
- CNT_W=2, key held long -> Step_Count 1, 2, 3, 3, 3 while Step keeps pulsing.
- REPEAT_EN=0, key held 40 cycles -> one Step, Timer_Start never asserted; release then press -> one more Step.

Source files
------------

// File: rtl/key_repeat_sequencer.sv
// rtl/key_repeat_sequencer.sv - held-key auto-repeat step sequencer driving an external start/done timer pair
module key_repeat_sequencer #(
    parameter int CNT_W     = 8,
    parameter bit REPEAT_EN = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Key_Held,
    input  logic             Timer_Done,
    output logic             Timer_Start,
    output logic             Timer_Long,
    output logic             Step,
    output logic             Repeating,
    output logic [CNT_W-1:0] Step_Count
);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] WAIT_FIRST  = 2'd1;
    localparam logic [1:0] WAIT_REPEAT = 2'd2;
    localparam logic [1:0] HOLD        = 2'd3;

    logic [1:0]       state;
    logic             key_prev;
    logic             press;
    logic             timer_ok;
    logic [CNT_W-1:0] count_next;

    assign press = Key_Held & ~key_prev;
    // The timer only loads on the edge after Start, so its Done is stale while Start is high.
    assign timer_ok   = Timer_Done & ~Timer_Start;
    assign count_next = (&Step_Count) ? Step_Count : Step_Count + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            key_prev    <= 1'b1;
            Timer_Start <= 1'b0;
            Timer_Long  <= 1'b1;
            Step        <= 1'b0;
            Repeating   <= 1'b0;
            Step_Count  <= '0;
        end else begin
            key_prev    <= Key_Held;
            Step        <= 1'b0;
            Timer_Start <= 1'b0;
            case (state)
                IDLE: begin
                    Step_Count <= '0;
                    Repeating  <= 1'b0;
                    Timer_Long <= 1'b1;
                    if (press) begin
                        Step       <= 1'b1;
                        Step_Count <= CNT_W'(1);
                        if (REPEAT_EN) begin
                            Timer_Start <= 1'b1;
                            state       <= WAIT_FIRST;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                WAIT_FIRST: begin
                    if (!Key_Held) begin
                        state      <= IDLE;
                        Step_Count <= '0;
                    end else if (timer_ok) begin
                        Step        <= 1'b1;
                        Step_Count  <= count_next;
                        Timer_Start <= 1'b1;
                        Timer_Long  <= 1'b0;
                        Repeating   <= 1'b1;
                        state       <= WAIT_REPEAT;
                    end
                end
                WAIT_REPEAT: begin
                    // Release takes priority over a coincident Done.
                    if (!Key_Held) begin
                        state      <= IDLE;
                        Step_Count <= '0;
                        Repeating  <= 1'b0;
                        Timer_Long <= 1'b1;
                    end else if (timer_ok) begin
                        Step        <= 1'b1;
                        Step_Count  <= count_next;
                        Timer_Start <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!Key_Held) begin
                        state      <= IDLE;
                        Step_Count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_repeat_sequencer.sv
// tb/tb_key_repeat_sequencer.sv - randomized timeline-model bench for key_repeat_sequencer
module tb_key_repeat_sequencer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset;
    logic       Key_Held;
    logic [2:0] done, ts, tl, stp, rpt;
    logic [7:0] sc0, sc2;
    logic [1:0] sc1;

    int pl = 5;
    int ps = 2;
    int cl[3];
    int cs[3];

    key_repeat_sequencer #(.CNT_W(8), .REPEAT_EN(1'b1)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .Key_Held(Key_Held), .Timer_Done(done[0]),
        .Timer_Start(ts[0]), .Timer_Long(tl[0]), .Step(stp[0]), .Repeating(rpt[0]),
        .Step_Count(sc0)
    );
    key_repeat_sequencer #(.CNT_W(2), .REPEAT_EN(1'b1)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .Key_Held(Key_Held), .Timer_Done(done[1]),
        .Timer_Start(ts[1]), .Timer_Long(tl[1]), .Step(stp[1]), .Repeating(rpt[1]),
        .Step_Count(sc1)
    );
    key_repeat_sequencer #(.CNT_W(8), .REPEAT_EN(1'b0)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .Key_Held(Key_Held), .Timer_Done(done[2]),
        .Timer_Start(ts[2]), .Timer_Long(tl[2]), .Step(stp[2]), .Repeating(rpt[2]),
        .Step_Count(sc2)
    );

    // External timer pair per DUT: loads on Start, counts to zero, idle reads Done=1.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (Reset) begin
                cl[i] <= 0;
                cs[i] <= 0;
            end else begin
                if (ts[i] && tl[i]) cl[i] <= pl;
                else if (cl[i] != 0) cl[i] <= cl[i] - 1;
                if (ts[i] && !tl[i]) cs[i] <= ps;
                else if (cs[i] != 0) cs[i] <= cs[i] - 1;
            end
        end
    end

    always_comb begin
        done = '0;
        for (int i = 0; i < 3; i++)
            done[i] = tl[i] ? (cl[i] == 0) : (cs[i] == 0);
    end

    // Timeline model: phase 0 idle, 1 first delay, 2 repeating, 3 single-step hold.
    bit rep_en[3] = '{1'b1, 1'b1, 1'b0};
    int cmax[3]   = '{255, 3, 255};
    int m_phase[3];
    int m_next[3];
    int m_cnt[3];
    bit m_step[3];
    bit m_tst[3];
    bit m_kprev = 1'b1;
    int edge_n  = 0;
    int tot_steps[3];
    int tot_starts[3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got %0d want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit key);
        for (int i = 0; i < 3; i++) begin
            m_step[i] = 1'b0;
            m_tst[i]  = 1'b0;
            if (rst) begin
                m_phase[i] = 0;
                m_cnt[i]   = 0;
            end else if (m_phase[i] == 0) begin
                if (key && !m_kprev) begin
                    m_step[i] = 1'b1;
                    m_cnt[i]  = 1;
                    if (rep_en[i]) begin
                        m_phase[i] = 1;
                        m_tst[i]   = 1'b1;
                        m_next[i]  = edge_n + pl + 2;
                    end else begin
                        m_phase[i] = 3;
                    end
                end
            end else if (!key) begin
                m_phase[i] = 0;
                m_cnt[i]   = 0;
            end else if (m_phase[i] != 3 && edge_n == m_next[i]) begin
                m_step[i]  = 1'b1;
                m_tst[i]   = 1'b1;
                m_cnt[i]   = (m_cnt[i] < cmax[i]) ? m_cnt[i] + 1 : m_cnt[i];
                m_phase[i] = 2;
                m_next[i]  = edge_n + ps + 2;
            end
        end
        m_kprev = rst ? 1'b1 : key;
        edge_n++;
    endtask

    task automatic compare();
        logic [31:0] obs_sc;
        for (int i = 0; i < 3; i++) begin
            obs_sc = (i == 0) ? 32'(sc0) : (i == 1) ? 32'(sc1) : 32'(sc2);
            chk($sformatf("step%0d", i), 32'(stp[i]), 32'(m_step[i]));
            chk($sformatf("start%0d", i), 32'(ts[i]), 32'(m_tst[i]));
            chk($sformatf("long%0d", i), 32'(tl[i]), (m_phase[i] == 2) ? 32'd0 : 32'd1);
            chk($sformatf("repeating%0d", i), 32'(rpt[i]), (m_phase[i] == 2) ? 32'd1 : 32'd0);
            chk($sformatf("count%0d", i), obs_sc, 32'(m_cnt[i]));
            tot_steps[i]  += int'(stp[i]);
            tot_starts[i] += int'(ts[i]);
        end
    endtask

    task automatic tick(input bit rst, input bit key);
        Reset    = rst;
        Key_Held = key;
        @(posedge Clk);
        model_edge(rst, key);
        @(negedge Clk);
        compare();
    endtask

    int base0, base2;

    initial begin
        repeat (2) tick(1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b0);

        // Single-cycle tap.
        base0 = tot_steps[0];
        tick(1'b0, 1'b1);
        repeat (10) tick(1'b0, 1'b0);
        chk("tap_steps", 32'(tot_steps[0] - base0), 32'd1);

        // Long hold: steps at 1,8,12,...,28; narrow counter saturates.
        base0 = tot_steps[0];
        repeat (30) tick(1'b0, 1'b1);
        chk("hold30_steps", 32'(tot_steps[0] - base0), 32'd7);
        chk("hold30_sat", 32'(sc1), 32'd3);
        repeat (5) tick(1'b0, 1'b0);

        // Release on the edge that sees the first-delay Done.
        base0 = tot_steps[0];
        repeat (7) tick(1'b0, 1'b1);
        repeat (5) tick(1'b0, 1'b0);
        chk("release_at_done_steps", 32'(tot_steps[0] - base0), 32'd1);

        // Key held through reset must be released and re-pressed.
        repeat (2) tick(1'b1, 1'b1);
        base0 = tot_steps[0];
        repeat (6) tick(1'b0, 1'b1);
        chk("held_thru_reset_steps", 32'(tot_steps[0] - base0), 32'd0);
        tick(1'b0, 1'b0);
        repeat (12) tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);

        // Zero-length timers.
        pl = 0;
        ps = 0;
        repeat (15) tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        pl = 5;
        ps = 2;

        // Single-step instance: one step per press, no timer activity.
        base2 = tot_steps[2];
        repeat (40) tick(1'b0, 1'b1);
        chk("norep_hold_steps", 32'(tot_steps[2] - base2), 32'd1);
        tick(1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b1);
        chk("norep_repress_steps", 32'(tot_steps[2] - base2), 32'd2);
        tick(1'b0, 1'b0);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) begin
                pl = $urandom_range(0, 6);
                ps = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 5) == 0)
                repeat ($urandom_range(1, 2)) tick(1'b1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 25)) tick(1'b0, 1'b1);
            if ($urandom_range(0, 5) == 0) begin
                tick(1'b1, 1'b1);
                repeat ($urandom_range(1, 5)) tick(1'b0, 1'b1);
            end
            repeat ($urandom_range(1, 4)) tick(1'b0, 1'b0);
        end

        chk("norep_no_starts", 32'(tot_starts[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
